// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder feeding a small result FIFO: each accepted request is decoded
// at push time, queued as {alu_ctrl, illegal}, and illegal decodes are tallied in err_cnt.
module alu_ctrl_pipe #(
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 alu_op,
    input  logic [5:0]                 funct,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          alu_ctrl,
    output logic                       illegal,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           err_cnt,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              illegal;
    } entry_t;

    function automatic entry_t decode(input logic [1:0] op, input logic [5:0] f);
        entry_t     e;
        logic [3:0] code;
        logic       bad;
        code = 4'b0000;
        bad  = 1'b0;
        unique case (op)
            2'b00: code = 4'b0010;
            2'b01: code = 4'b0110;
            2'b10: begin
                unique case (f)
                    6'b100000: code = 4'b0010;
                    6'b100010: code = 4'b0110;
                    6'b100100: code = 4'b0000;
                    6'b100101: code = 4'b0001;
                    6'b100110: code = 4'b0011;
                    6'b100111: code = 4'b1100;
                    6'b101010: code = 4'b0111;
                    6'b101011: code = 4'b1010;
                    6'b000000: code = 4'b1000;
                    6'b000010: code = 4'b1001;
                    default:   bad  = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        e.ctrl    = bad ? {CTRL_W{1'b1}} : CTRL_W'(code);
        e.illegal = bad;
        return e;
    endfunction

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    entry_t push_entry;
    entry_t head;
    logic   push;
    logic   pop;

    // Readiness is gated by rst so it drops the instant reset asserts; a full FIFO
    // never accepts, even when the head is being popped in the same cycle.
    assign in_ready   = rst && (level_q != LW'(DEPTH));
    assign out_valid  = (level_q != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign push_entry = decode(alu_op, funct);
    assign head       = mem_q[rd_ptr_q];

    assign alu_ctrl = out_valid ? head.ctrl : '0;
    assign illegal  = out_valid ? head.illegal : 1'b0;
    assign level    = level_q;
    assign err_cnt  = err_cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (push && push_entry.illegal && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; its contents are never visible while level is 0,
    // so clearing the pointers and level is enough and keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe (DEPTH=4, CNT_W=2) with hand-computed expectations.
module tb_alu_ctrl_pipe;

    localparam int CTRL_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic [2:0]        level;
    logic [CNT_W-1:0]  err_cnt;
    logic              clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_ctrl_pipe #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .illegal   (illegal),
        .level     (level),
        .err_cnt   (err_cnt),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [5:0] f);
        in_valid = 1'b1;
        alu_op   = op;
        funct    = f;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic head_is(input string tag, input logic [3:0] ctrl, input logic ill);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_ctrl"}, alu_ctrl, ctrl);
        check({tag, "_ill"}, illegal, ill);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; alu_op = 2'b00; funct = 6'b0;
        out_ready = 1'b0; clr_err = 1'b0;
        #3;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_err_cnt", err_cnt, 2'd0);
        check("rst_alu_ctrl", alu_ctrl, 4'h0);
        check("rst_illegal", illegal, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        tick();

        // nor through an empty FIFO, consumer ready
        out_ready = 1'b1;
        push(2'b10, 6'b100111);
        head_is("nor", 4'b1100, 1'b0);
        check("nor_level", level, 3'd1);
        tick();
        check("nor_drained_valid", out_valid, 1'b0);
        check("nor_drained_level", level, 3'd0);
        out_ready = 1'b0;

        // fill to DEPTH, then a refused illegal request
        push(2'b00, 6'b111111);
        push(2'b01, 6'b000000);
        push(2'b10, 6'b101011);
        push(2'b10, 6'b000010);
        check("full_in_ready", in_ready, 1'b0);
        check("full_level", level, 3'd4);
        push(2'b11, 6'b000000);
        check("refused_level", level, 3'd4);
        check("refused_err_cnt", err_cnt, 2'd0);
        head_is("fifo0", 4'b0010, 1'b0);
        pop_one();
        head_is("fifo1", 4'b0110, 1'b0);
        pop_one();
        head_is("fifo2", 4'b1010, 1'b0);
        pop_one();
        head_is("fifo3", 4'b1001, 1'b0);
        pop_one();
        check("fifo_empty_valid", out_valid, 1'b0);
        check("fifo_empty_ctrl", alu_ctrl, 4'h0);
        check("fifo_empty_level", level, 3'd0);

        // illegal decodes
        push(2'b11, 6'b100000);
        push(2'b10, 6'b111111);
        check("ill_err_cnt", err_cnt, 2'd2);
        head_is("ill0", 4'b1111, 1'b1);
        pop_one();
        head_is("ill1", 4'b1111, 1'b1);
        pop_one();
        check("ill_empty_ill", illegal, 1'b0);

        // saturation and clear priority
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err_cnt", err_cnt, 2'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 2'b11;
        tick(); check("sat1", err_cnt, 2'd1);
        tick(); check("sat2", err_cnt, 2'd2);
        tick(); check("sat3", err_cnt, 2'd3);
        tick(); check("sat4", err_cnt, 2'd3);
        tick(); check("sat5", err_cnt, 2'd3);
        check("stream_level", level, 3'd1);
        clr_err = 1'b1;
        tick();
        check("clr_vs_inc", err_cnt, 2'd0);
        in_valid = 1'b0;
        clr_err  = 1'b0;
        tick();
        out_ready = 1'b0;
        check("sat_drained_level", level, 3'd0);

        // simultaneous push/pop mid-range and at full
        push(2'b00, 6'b000000);
        push(2'b01, 6'b000000);
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b100100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp_mid_level", level, 3'd2);
        head_is("pp_mid_head", 4'b0110, 1'b0);
        push(2'b10, 6'b100101);
        push(2'b10, 6'b101010);
        check("pp_full_level", level, 3'd4);
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b100000; out_ready = 1'b1;
        #1;
        check("pp_full_in_ready", in_ready, 1'b0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pp_full_level_after", level, 3'd3);
        head_is("pp_q0", 4'b0000, 1'b0);
        pop_one();
        head_is("pp_q1", 4'b0001, 1'b0);
        pop_one();
        head_is("pp_q2", 4'b0111, 1'b0);
        pop_one();
        check("pp_empty_level", level, 3'd0);

        // asynchronous reset with entries queued
        push(2'b10, 6'b100110);
        push(2'b10, 6'b000000);
        push(2'b10, 6'b100010);
        check("ar_level_before", level, 3'd3);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_level", level, 3'd0);
        check("ar_in_ready", in_ready, 1'b0);
        check("ar_alu_ctrl", alu_ctrl, 4'h0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("ar_rel_in_ready", in_ready, 1'b1);
        check("ar_rel_out_valid", out_valid, 1'b0);
        check("ar_rel_level", level, 3'd0);
        push(2'b10, 6'b000010);
        head_is("ar_rel_head", 4'b1001, 1'b0);
        check("ar_rel_level1", level, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 Parameter CTRL_W, default 4: ALU control width; SHALL be >= 4, and codes are zero-extended to CTRL_W.
REQ-002 Parameter DEPTH, default 4: result FIFO depth; SHALL be a power of two and >= 2.
REQ-003 Parameter CNT_W, default 8: illegal-decode counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request accepted when in_valid and in_ready are both 1.
REQ-008 alu_op  in  2  ALUOp from main control.
REQ-009 funct  in  6  instruction bits [5:0].
REQ-010 out_valid  out  1  decoded result available at FIFO head.
REQ-011 out_ready  in  1  consumer takes the head entry when out_valid and out_ready are both 1.
REQ-012 alu_ctrl  out  CTRL_W  decoded ALU control of the head entry.
REQ-013 illegal  out  1  head entry decoded as illegal.
REQ-014 level  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 err_cnt  out  CNT_W  saturating count of illegal decodes pushed.
REQ-016 clr_err  in  1  synchronous clear of err_cnt.

Function
REQ-017 Decode SHALL be applied at push; the FIFO SHALL store the {alu_ctrl, illegal} pair.
REQ-018 alu_op 00 SHALL decode to 0010, legal (lw/sw/addi).
REQ-019 alu_op 01 SHALL decode to 0110, legal (beq/bne).
REQ-020 alu_op 10 SHALL decode on all 6 funct bits: 100000 to 0010 (add); 100010 to 0110 (sub); 100100 to 0000 (and); 100101 to 0001 (or); 100110 to 0011 (xor); 100111 to 1100 (nor); 101010 to 0111 (slt); 101011 to 1010 (sltu); 000000 to 1000 (sll); 000010 to 1001 (srl).
REQ-021 Any other funct with alu_op 10, and any alu_op 11, SHALL decode to all-ones alu_ctrl with illegal=1.
REQ-022 in_ready SHALL equal (level != DEPTH) and rst=1; there is no pass-through when full, even if a pop occurs that cycle.
REQ-023 Push then out_valid: minimum latency 1 cycle; an entry pushed into an empty FIFO SHALL be visible at the head on the next cycle.
REQ-024 out_valid SHALL equal (level != 0); when empty, alu_ctrl and illegal SHALL be driven to 0.
REQ-025 Ordering SHALL be strict FIFO; read/write pointers SHALL wrap modulo DEPTH.
REQ-026 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged.
REQ-027 Once out_valid is asserted, the head entry SHALL remain stable until popped.
REQ-028 err_cnt SHALL increment by 1 on each accepted push that decodes illegal, saturating at 2^CNT_W-1.
REQ-029 clr_err SHALL set err_cnt to 0 next cycle; clr_err takes priority over a simultaneous increment.
REQ-030 Requests with in_valid=1 while in_ready=0 SHALL NOT be stored or counted.

Reset
REQ-031 While rst=0: pointers=0, level=0, out_valid=0, in_ready=0, alu_ctrl=0, illegal=0, err_cnt=0; the effect SHALL be immediate, with no clock needed.
REQ-032 Reset asserted mid-operation SHALL discard all FIFO contents; the first cycle after release SHALL show in_ready=1, out_valid=0.

Verification
REQ-033 Reset, then push alu_op=10 funct=100111 with out_ready=1 -> next cycle out_valid=1, alu_ctrl=1100, illegal=0, then empty.
REQ-034 With out_ready=0, push DEPTH=4 entries (00, 01, 10/101011, 10/000010) -> in_ready=0, level=4; then pop 4 -> 0010, 0110, 1010, 1001 in order.
REQ-035 Push alu_op=11, then alu_op=10 funct=111111 -> both heads show alu_ctrl=1111, illegal=1; err_cnt=2.
REQ-036 With CNT_W=2, push 5 illegal entries -> err_cnt saturates at 3; clr_err coincident with a 6th illegal push -> err_cnt=0.
REQ-037 At level=2, push and pop in the same cycle -> level stays 2 and the data order is preserved; when full with push and pop together, the push is refused and level becomes 3.
REQ-038 Drop rst to 0 asynchronously between edges with 3 entries queued -> out_valid=0 and level=0 immediately; after release the FIFO is empty.
